sib_pulse_xfer_arb: RTL and testbench

- Arbiter and sequencer that shares one pulse clock-domain-crossing channel (the team's sib_sync_pulse instance) among NREQ requesters in the transmit clock domain.
- Latches single-cycle request pulses, picks one requester round-robin, and presents its ID as quasi-static data before issuing the crossing pulse.
- Holds the ID stable until the crossing reports transfer complete, then acknowledges the requester.
- Sits on the tx side, between filter-control event sources and the crossing channel.

---
 rtl/sib_pulse_arb_pkg.sv | 15 +
 rtl/sib_rr_arb.sv | 28 ++
 rtl/sib_pulse_xfer_arb.sv | 129 ++++++++++++
 tb/tb_sib_pulse_xfer_arb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sib_pulse_arb_pkg.sv
// Shared types and default constants for the pulse-crossing arbiter.
package sib_pulse_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StPulse  = 2'd2,
    StWait   = 2'd3
  } arb_state_e;

  localparam int unsigned NREQ_DEFAULT      = 4;
  localparam int unsigned SETUP_CYC_DEFAULT = 2;
  localparam int unsigned TMO_CYC_DEFAULT   = 1024;

endpackage

// File: rtl/sib_rr_arb.sv
// Combinational round-robin picker: first pending index strictly after ptr, wrapping.
module sib_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] pend,
  input  logic [IDW-1:0]  ptr,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_idx
);

  logic [IDW-1:0] cand;

  // Scan from farthest to nearest so the nearest pending index wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      cand = IDW'((int'(ptr) + k) % int'(NREQ));
      if (pend[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sib_pulse_xfer_arb.sv
// Round-robin arbiter/sequencer sharing one pulse CDC channel among NREQ tx-side requesters.
module sib_pulse_xfer_arb
  import sib_pulse_arb_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEFAULT,
  parameter int unsigned IDW       = 2,
  parameter int unsigned SETUP_CYC = SETUP_CYC_DEFAULT,
  parameter int unsigned TMO_CYC   = TMO_CYC_DEFAULT,
  parameter int unsigned TMO_W     = 11
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            ovf_clr_i,
  output logic            xfer_pulse_o,
  output logic [IDW-1:0]  xfer_id_o,
  input  logic            xfer_done_i,
  output logic [NREQ-1:0] ack_o,
  output logic            busy_o,
  output logic [NREQ-1:0] pend_o,
  output logic [NREQ-1:0] ovf_o,
  output logic            tmo_o
);

  localparam int unsigned SW = $clog2(SETUP_CYC) + 1;

  arb_state_e      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [SW-1:0]   setup_q, setup_d;
  logic [TMO_W-1:0] wdg_q, wdg_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] ovf_q, ovf_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            tmo_q, tmo_d, tmo_set;
  logic            gnt_valid, grant;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] clr_mask;

  sib_rr_arb #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_rr_arb (
    .pend     (pend_q),
    .ptr      (ptr_q),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  assign grant    = (state_q == StIdle) && en_i && gnt_valid;
  assign clr_mask = grant ? (NREQ'(1) << gnt_idx) : '0;

  // A request coinciding with its own clearing grant re-arms pend instead of overflowing.
  assign pend_d = (pend_q & ~clr_mask) | req_i;
  assign ovf_d  = (ovf_q & ~{NREQ{ovf_clr_i}}) | (req_i & pend_q & ~clr_mask);
  assign tmo_d  = tmo_set | (tmo_q & ~ovf_clr_i);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    setup_d = setup_q;
    wdg_d   = wdg_q;
    ack_d   = '0;
    tmo_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          setup_d = SW'(SETUP_CYC - 1);
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (setup_q == '0) state_d = StPulse;
        else               setup_d = setup_q - SW'(1);
      end
      StPulse: begin
        // Counter tracks cycles elapsed since the pulse, so the pulse cycle counts as one.
        wdg_d   = TMO_W'(1);
        state_d = StWait;
      end
      StWait: begin
        if (xfer_done_i) begin
          ack_d   = NREQ'(1) << id_q;
          state_d = StIdle;
        end else if (wdg_q < TMO_W'(TMO_CYC)) begin
          wdg_d   = wdg_q + TMO_W'(1);
          tmo_set = (wdg_q == TMO_W'(TMO_CYC - 1));
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      setup_q <= '0;
      wdg_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      ack_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      setup_q <= setup_d;
      wdg_q   <= wdg_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
    end
  end

  assign xfer_pulse_o = (state_q == StPulse);
  assign xfer_id_o    = id_q;
  assign ack_o        = ack_q;
  assign busy_o       = (state_q != StIdle);
  assign pend_o       = pend_q;
  assign ovf_o        = ovf_q;
  assign tmo_o        = tmo_q;

endmodule

// File: tb/tb_sib_pulse_xfer_arb.sv
// Scoreboard bench: stimulus queues expected pulses/acks, a negedge monitor pops and compares.
module tb_sib_pulse_xfer_arb;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       en_i;
  logic [3:0] req_i;
  logic       ovf_clr_i;
  logic       xfer_pulse_o;
  logic [1:0] xfer_id_o;
  logic       xfer_done_i;
  logic [3:0] ack_o;
  logic       busy_o;
  logic [3:0] pend_o;
  logic [3:0] ovf_o;
  logic       tmo_o;

  sib_pulse_xfer_arb dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .req_i       (req_i),
    .ovf_clr_i   (ovf_clr_i),
    .xfer_pulse_o(xfer_pulse_o),
    .xfer_id_o   (xfer_id_o),
    .xfer_done_i (xfer_done_i),
    .ack_o       (ack_o),
    .busy_o      (busy_o),
    .pend_o      (pend_o),
    .ovf_o       (ovf_o),
    .tmo_o       (tmo_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int val;
    int cyc;  // -1: cycle not checked
  } exp_t;

  exp_t pulse_q[$];
  exp_t ack_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every pulse/ack presented by the DUT must match the head of its queue.
  always @(negedge clk_i) begin
    exp_t e;
    if (xfer_pulse_o === 1'b1) begin
      if (pulse_q.size() == 0) begin
        check("unexpected_pulse_id", 32'(xfer_id_o), 32'hffff_ffff);
      end else begin
        e = pulse_q.pop_front();
        check("pulse_id", 32'(xfer_id_o), 32'(e.val));
        if (e.cyc >= 0) check("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (ack_o !== 4'b0000) begin
      if (ack_q.size() == 0) begin
        check("unexpected_ack", 32'(ack_o), 32'h0);
      end else begin
        e = ack_q.pop_front();
        check("ack_vector", 32'(ack_o), 32'(e.val));
        if (e.cyc >= 0) check("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push_pulse(input int id, input int c);
    exp_t e;
    e.val = id;
    e.cyc = c;
    pulse_q.push_back(e);
  endtask

  task automatic push_ack(input int v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    ack_q.push_back(e);
  endtask

  task automatic wait_pulse();
    int n = 0;
    while (xfer_pulse_o !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (xfer_pulse_o !== 1'b1) check("pulse_timeout", 32'(xfer_pulse_o), 32'h1);
  endtask

  task automatic done_after(input int k);
    repeat (k) tick();
    xfer_done_i = 1'b1;
    tick();
    xfer_done_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse"}, 32'(xfer_pulse_o), 32'h0);
    check({tag, "_id"},    32'(xfer_id_o),    32'h0);
    check({tag, "_ack"},   32'(ack_o),        32'h0);
    check({tag, "_busy"},  32'(busy_o),       32'h0);
    check({tag, "_pend"},  32'(pend_o),       32'h0);
    check({tag, "_ovf"},   32'(ovf_o),        32'h0);
    check({tag, "_tmo"},   32'(tmo_o),        32'h0);
  endtask

  initial begin
    int c;
    int p;
    rst_ni      = 1'b0;
    en_i        = 1'b1;
    req_i       = '0;
    ovf_clr_i   = 1'b0;
    xfer_done_i = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_ni = 1'b1;
    tick();

    // Round-robin from reset: 0,1,2,3 with 1+SETUP_CYC gap after each ack.
    c = cyc;
    req_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      push_pulse(i, c + 4 + 9 * i);
      push_ack(1 << i, c + 10 + 9 * i);
    end
    tick();
    req_i = '0;
    for (int i = 0; i < 4; i++) begin
      wait_pulse();
      done_after(5);
    end
    check("rr_ovf", 32'(ovf_o), 32'h0);
    check("rr_pend", 32'(pend_o), 32'h0);

    // Single request timing.
    c = cyc;
    req_i = 4'b0100;
    push_pulse(2, c + 4);
    push_ack(4'b0100, c + 11);
    tick();
    req_i = '0;
    check("single_pend", 32'(pend_o), 32'h4);
    tick();
    check("single_id", 32'(xfer_id_o), 32'h2);
    check("single_busy", 32'(busy_o), 32'h1);
    check("single_pend_clr", 32'(pend_o), 32'h0);
    tick_to(c + 10);
    xfer_done_i = 1'b1;
    tick();
    xfer_done_i = 1'b0;
    check("single_idle", 32'(busy_o), 32'h0);

    // Overflow merge: double request while held off by en_i.
    en_i  = 1'b0;
    req_i = 4'b0010;
    tick();
    tick();
    req_i = '0;
    check("ovf_set", 32'(ovf_o), 32'h2);
    check("ovf_pend", 32'(pend_o), 32'h2);
    push_pulse(1, -1);
    push_ack(4'b0010, -1);
    en_i = 1'b1;
    wait_pulse();
    done_after(3);
    tick();
    check("ovf_one_xfer", 32'(pend_o), 32'h0);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("ovf_clr", 32'(ovf_o), 32'h0);

    // Coincident re-request in the grant cycle of ID 3.
    c = cyc;
    req_i = 4'b1000;
    push_pulse(3, c + 4);
    push_ack(4'b1000, c + 7);
    push_pulse(3, c + 10);
    push_ack(4'b1000, c + 13);
    tick();
    tick();
    req_i = '0;
    check("coin_pend", 32'(pend_o), 32'h8);
    check("coin_ovf", 32'(ovf_o), 32'h0);
    check("coin_id", 32'(xfer_id_o), 32'h3);
    wait_pulse();
    done_after(2);
    wait_pulse();
    done_after(2);
    check("coin_pend_end", 32'(pend_o), 32'h0);
    check("coin_ovf_end", 32'(ovf_o), 32'h0);

    // Watchdog: withhold done for 1100 cycles after the pulse.
    req_i = 4'b0001;
    push_pulse(0, -1);
    tick();
    req_i = '0;
    wait_pulse();
    p = cyc;
    tick_to(p + 1023);
    check("tmo_early", 32'(tmo_o), 32'h0);
    tick();
    check("tmo_set", 32'(tmo_o), 32'h1);
    check("tmo_busy", 32'(busy_o), 32'h1);
    tick_to(p + 1100);
    check("tmo_still_busy", 32'(busy_o), 32'h1);
    push_ack(4'b0001, p + 1101);
    xfer_done_i = 1'b1;
    tick();
    xfer_done_i = 1'b0;
    check("tmo_late_done", 32'(busy_o), 32'h0);
    check("tmo_sticky", 32'(tmo_o), 32'h1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    check("tmo_clr", 32'(tmo_o), 32'h0);

    // Enable gating, done ignored in IDLE, then reset during WAIT.
    en_i  = 1'b0;
    req_i = 4'b0011;
    tick();
    req_i = '0;
    repeat (5) tick();
    check("en_pend", 32'(pend_o), 32'h3);
    check("en_idle", 32'(busy_o), 32'h0);
    xfer_done_i = 1'b1;
    tick();
    xfer_done_i = 1'b0;
    check("idle_done_ignored", 32'(busy_o), 32'h0);
    c = cyc;
    en_i = 1'b1;
    push_pulse(1, c + 3);
    tick();
    check("en_resume", 32'(busy_o), 32'h1);
    wait_pulse();
    tick();
    tick();
    rst_ni = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_ni = 1'b1;
    req_i  = 4'b1001;
    push_pulse(0, -1);
    push_ack(4'b0001, -1);
    push_pulse(3, -1);
    push_ack(4'b1000, -1);
    tick();
    req_i = '0;
    wait_pulse();
    done_after(2);
    wait_pulse();
    done_after(2);

    repeat (20) tick();
    check("pulse_queue_drained", 32'(pulse_q.size()), 32'h0);
    check("ack_queue_drained", 32'(ack_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
